// File: rtl/coin_pkg.sv
// Shared coin-path definitions: coin codes, cent values, front-end widths.
// Coin code values are fixed; the coin queue stores them as raw 2-bit codes.
// Cent constants are shared with the vending FSM and change logic.
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE    = 2'b00,
    COIN_NICKEL  = 2'b01,
    COIN_DIME    = 2'b10,
    COIN_QUARTER = 2'b11
  } coin_e;

  localparam int unsigned NICKEL_CENTS  = 5;
  localparam int unsigned DIME_CENTS    = 10;
  localparam int unsigned QUARTER_CENTS = 25;

  // Debounce counter covers DEBOUNCE_CYCLES up to 255, gap counter up to 15.
  localparam int unsigned DEBOUNCE_W = 8;
  localparam int unsigned GAP_W      = 4;

  typedef enum logic [1:0] {
    EMIT_IDLE  = 2'b00,
    EMIT_PULSE = 2'b01,
    EMIT_GAP   = 2'b10
  } emit_state_e;

endpackage

// File: rtl/coin_debounce.sv
// Purpose: 2-flop synchronizer + debounce counter + rising-edge detect for one coin chute.
// Latency: rise pulses in the cycle after edge k+1+DEBOUNCE_CYCLES when raw is stable from edge k.
// Ports: clk, rst (async, active-high), raw (asynchronous bouncy switch), rise (one-cycle pulse).
module coin_debounce
  import coin_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam logic [DEBOUNCE_W-1:0] CNT_LAST = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

  logic                  sync1;
  logic                  sync2;
  logic                  level;
  logic [DEBOUNCE_W-1:0] cnt;
  logic                  flip;

  // The level flips on the edge where the counter would reach DEBOUNCE_CYCLES.
  assign flip = (sync2 != level) && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Registered edge detect: high for exactly the cycle after level goes 0->1.
      rise  <= flip && sync2;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (flip) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/coin_front_end.sv
// Purpose: debounce three coin chutes, queue accepted coins, emit one one-hot coin pulse at a time.
// Latency: coin pulse in the cycle after edge k+DEBOUNCE_CYCLES+3 (raw stable from edge k, idle path).
// Ports: clk, rst (async, active-high), nickel/dime/quarter_raw in; Nickel/Dime/Quarter,
//        coin_reject, busy out; reject_count out only when COIN_FE_STATS_EN is defined.
module coin_front_end
  import coin_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned GAP_CYCLES      = 1,
  parameter int unsigned QDEPTH          = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nickel_raw,
  input  logic       dime_raw,
  input  logic       quarter_raw,
  output logic       Nickel,
  output logic       Dime,
  output logic       Quarter,
  output logic       coin_reject,
  output logic       busy
`ifdef COIN_FE_STATS_EN
  ,
  output logic [7:0] reject_count
`endif
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0]    QDEPTH_C = CW'(QDEPTH);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  // ev[0]=nickel, ev[1]=dime, ev[2]=quarter; index i maps to coin code i+1.
  logic [2:0] ev;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_nickel (
    .clk(clk), .rst(rst), .raw(nickel_raw), .rise(ev[0])
  );
  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dime (
    .clk(clk), .rst(rst), .raw(dime_raw), .rise(ev[1])
  );
  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_quarter (
    .clk(clk), .rst(rst), .raw(quarter_raw), .rise(ev[2])
  );

  coin_e          mem [QDEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_nxt;
  logic [CW-1:0]  free_slots;
  logic [2:0]     wr_en;
  logic [PW-1:0]  wr_idx [3];
  logic [1:0]     n_push;
  logic [1:0]     n_drop;
  coin_e          head;

  emit_state_e      state;
  emit_state_e      state_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_nxt;
  logic             pop;

  assign head = mem[rd_ptr];

  // Emitter next-state. A pop launches the pulse on the next edge, so the
  // last GAP cycle (or EMIT when there is no gap) may pop directly to keep
  // pulse starts exactly 1+GAP_CYCLES apart.
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    pop       = 1'b0;
    case (state)
      EMIT_IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = EMIT_PULSE;
        end
      end
      EMIT_PULSE: begin
        if (GAP_CYCLES == 0) begin
          if (count != '0) begin
            pop = 1'b1;
          end else begin
            state_nxt = EMIT_IDLE;
          end
        end else begin
          state_nxt = EMIT_GAP;
          gap_nxt   = '0;
        end
      end
      EMIT_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (count != '0) begin
            pop       = 1'b1;
            state_nxt = EMIT_PULSE;
          end else begin
            state_nxt = EMIT_IDLE;
          end
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      default: state_nxt = EMIT_IDLE;
    endcase
  end

  // Push allocation in fixed nickel, dime, quarter order; once free space is
  // used up, every later event in that order is dropped.
  always_comb begin
    free_slots = QDEPTH_C - count + CW'(pop);
    n_push     = '0;
    n_drop     = '0;
    wr_en      = '0;
    for (int i = 0; i < 3; i++) begin
      wr_idx[i] = wr_ptr + PW'(n_push);
      if (ev[i]) begin
        if (CW'(n_push) < free_slots) begin
          wr_en[i] = 1'b1;
          n_push   = n_push + 1'b1;
        end else begin
          n_drop = n_drop + 1'b1;
        end
      end
    end
    count_nxt = count + CW'(n_push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMIT_IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  // Queue storage needs no reset: count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (wr_en[i]) mem[wr_idx[i]] <= coin_e'(2'(i + 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      Nickel      <= 1'b0;
      Dime        <= 1'b0;
      Quarter     <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr + PW'(n_push);
      rd_ptr      <= rd_ptr + PW'(pop);
      count       <= count_nxt;
      Nickel      <= pop && (head == COIN_NICKEL);
      Dime        <= pop && (head == COIN_DIME);
      Quarter     <= pop && (head == COIN_QUARTER);
      coin_reject <= (n_drop != '0);
      busy        <= (count_nxt != '0) || (state_nxt != EMIT_IDLE);
    end
  end

`ifdef COIN_FE_STATS_EN
  logic [8:0] rc_sum;

  assign rc_sum = {1'b0, reject_count} + {7'b0, n_drop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reject_count <= '0;
    end else begin
      reject_count <= rc_sum[8] ? 8'hFF : rc_sum[7:0];
    end
  end
`endif

endmodule
